uart_tx: RTL

UART transmitter, the transmit-side counterpart of the UART-RX path (frames are compatible with the RX parity checker's even/odd convention). Accepts a parallel byte with a single-cycle valid strobe and serializes it on TX_OUT as start bit, data LSB-first, optional parity, and stop bit. clk is the TX bit clock, so one clk cycle equals one bit period. Sits in the UART peripheral between the bus-side TX register/FIFO and the serial pin.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_serializer.sv | 56 +++++
 rtl/uart_tx.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, line levels and parity convention.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package uart_pkg;

   // Transmit FSM states, in frame order.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   // Line levels on the serial pin.
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   // Parity type encoding. The RX checker uses the same values.
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Parity bit from the XOR-reduction of the data and the parity type.
   // Even: bit equals the XOR of the data. Odd: its complement.
   function automatic logic parity_bit(input logic xor_all, input logic par_typ);
      return (par_typ == PAR_ODD) ? ~xor_all : xor_all;
   endfunction

endpackage : uart_pkg

// File: rtl/uart_tx_serializer.sv
// Data shift register and bit counter for the UART transmitter.
// Latency: o_bit/o_last reflect state registered on the previous edge.
// Backpressure: none; the controlling FSM decides when to load, shift and clear.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_shift,
   input  logic                  i_clr,
   output logic                  o_bit,
   output logic                  o_last
);

   // One bit of counter is kept even for a single-bit frame.
   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [DATA_WIDTH-1:0] r_shift;
   logic [CNT_W-1:0]      r_cnt;
   logic                  w_last;

   // The counter indexes the data bit currently on the line while in DATA.
   assign w_last = (r_cnt == CNT_W'(DATA_WIDTH - 1));
   assign o_last = w_last;

   // LSB of the shift register is always the next data bit to be sent.
   assign o_bit  = r_shift[0];

   // Shift register: capture the byte on accept, move right once per bit sent.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shift <= '0;
      end else if (i_load) begin
         r_shift <= i_data;
      end else if (i_shift) begin
         r_shift <= r_shift >> 1;
      end
   end

   // Bit counter: cleared when DATA is entered, held at the last index so it
   // never wraps inside a frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_shift && !w_last) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule : uart_tx_serializer

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Latency: start bit on the line 1 cycle after Data_Valid is accepted; one clk = one bit.
// Backpressure: Data_Valid honoured only while busy==0; requests during a frame are dropped.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  busy
);

   tx_state_e r_state;
   tx_state_e w_state_nxt;

   logic r_tx;
   logic r_busy;
   logic r_par;
   logic r_par_en;

   logic w_tx_nxt;
   logic w_busy_nxt;
   logic w_load;
   logic w_shift;
   logic w_clr;
   logic w_ser_bit;
   logic w_ser_last;

   uart_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ser (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_data  (P_DATA),
      .i_shift (w_shift),
      .i_clr   (w_clr),
      .o_bit   (w_ser_bit),
      .o_last  (w_ser_last)
   );

   // State, line and busy registers; the line level is decided one cycle
   // ahead so TX_OUT comes straight from a flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_tx    <= IDLE_LEVEL;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tx    <= w_tx_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // Frame configuration captured on accept so upstream changes mid-frame
   // cannot disturb the frame in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_par    <= 1'b0;
         r_par_en <= 1'b0;
      end else if (w_load) begin
         r_par    <= parity_bit(^P_DATA, PAR_TYP);
         r_par_en <= PAR_EN;
      end
   end

   // Next state plus the line level and busy flag that go with it.
   always_comb begin
      w_state_nxt = r_state;
      w_tx_nxt    = IDLE_LEVEL;
      w_busy_nxt  = 1'b1;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_clr       = 1'b0;
      case (r_state)
         IDLE: begin
            w_busy_nxt = 1'b0;
            if (Data_Valid) begin
               w_state_nxt = START;
               w_tx_nxt    = START_BIT;
               w_busy_nxt  = 1'b1;
               w_load      = 1'b1;
            end
         end
         START: begin
            // First data bit goes out while the counter restarts at bit 0.
            w_state_nxt = DATA;
            w_tx_nxt    = w_ser_bit;
            w_shift     = 1'b1;
            w_clr       = 1'b1;
         end
         DATA: begin
            if (w_ser_last) begin
               if (r_par_en) begin
                  w_state_nxt = PARITY;
                  w_tx_nxt    = r_par;
               end else begin
                  w_state_nxt = STOP;
                  w_tx_nxt    = STOP_BIT;
               end
            end else begin
               w_tx_nxt = w_ser_bit;
               w_shift  = 1'b1;
            end
         end
         PARITY: begin
            w_state_nxt = STOP;
            w_tx_nxt    = STOP_BIT;
         end
         STOP: begin
            // Requests arriving here are dropped; the idle cycle is mandatory.
            w_state_nxt = IDLE;
            w_tx_nxt    = IDLE_LEVEL;
            w_busy_nxt  = 1'b0;
         end
         default: begin
            w_state_nxt = IDLE;
            w_tx_nxt    = IDLE_LEVEL;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   assign TX_OUT = r_tx;
   assign busy   = r_busy;

endmodule : uart_tx
